// File: rtl/skid_buffer.sv
// Two-entry skid buffer that decouples a valid/ready stream at full throughput.
// Optional synchronous flush port is enabled by defining SKID_BUFFER_FLUSH_EN.
module skid_buffer #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
`ifdef SKID_BUFFER_FLUSH_EN
  input  logic             flush,
`endif
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_nextState;
  logic [WIDTH-1:0] r_main;
  logic [WIDTH-1:0] r_skid;
  logic [WIDTH-1:0] w_mainNext;
  logic [WIDTH-1:0] w_skidNext;
  logic             r_inReady;
  logic             r_outValid;
  logic             w_inFire;
  logic             w_outFire;
  logic             w_flush;

`ifdef SKID_BUFFER_FLUSH_EN
  assign w_flush = flush;
`else
  assign w_flush = 1'b0;
`endif

  // Handshake flags are registered copies of the state, gated so nothing fires during reset or flush.
  assign in_ready  = r_inReady & reset & ~w_flush;
  assign out_valid = r_outValid & reset;
  assign out_data  = r_main;

  assign w_inFire  = in_valid & in_ready;
  assign w_outFire = out_valid & out_ready;

  always_comb begin
    w_nextState = r_state;
    w_mainNext  = r_main;
    w_skidNext  = r_skid;
    if (w_flush) begin
      w_nextState = EMPTY;
      w_mainNext  = '0;
      w_skidNext  = '0;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_inFire) begin
            w_mainNext  = in_data;
            w_nextState = BUSY;
          end
        end
        BUSY: begin
          if (w_inFire && !w_outFire) begin
            w_skidNext  = in_data;
            w_nextState = FULL;
          end else if (w_inFire && w_outFire) begin
            w_mainNext  = in_data;
          end else if (w_outFire) begin
            w_nextState = EMPTY;
          end
        end
        FULL: begin
          if (w_outFire) begin
            w_mainNext  = r_skid;
            w_nextState = BUSY;
          end
        end
        default: begin
          w_nextState = EMPTY;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= EMPTY;
      r_main     <= '0;
      r_skid     <= '0;
      r_inReady  <= 1'b1;
      r_outValid <= 1'b0;
    end else begin
      r_state    <= w_nextState;
      r_main     <= w_mainNext;
      r_skid     <= w_skidNext;
      r_inReady  <= (w_nextState != FULL);
      r_outValid <= (w_nextState != EMPTY);
    end
  end

endmodule

// File: doc/skid_buffer.md
SKID_BUFFER -- requirements
Module: skid_buffer

Interface
REQ-001: Parameter WIDTH, default 64, is the payload width in bits.
REQ-002: clk  input  1  is the single clock; all state updates occur on its rising edge.
REQ-003: reset  input  1  is the synchronous, active-low reset, sampled on the rising edge of clk.
REQ-004: in_data  input  WIDTH  is the upstream payload.
REQ-005: in_valid  input  1  is the upstream signal that in_data is valid.
REQ-006: in_ready  output  1  is the signal that the buffer accepts in_data this cycle.
REQ-007: out_data  output  WIDTH  is the downstream payload.
REQ-008: out_valid  output  1  is the signal that out_data is valid.
REQ-009: out_ready  input  1  is the downstream signal that it consumes out_data this cycle.
REQ-010: flush  input  1  is the synchronous discard of all held entries; it exists only under SKID_BUFFER_FLUSH_EN.

Function
REQ-011: An input transfer (in_fire) SHALL occur on a rising edge where in_valid and in_ready are both 1; an output transfer (out_fire) SHALL occur where out_valid and out_ready are both 1.
REQ-012: Storage SHALL be two WIDTH-bit registers: main (drives out_data) and skid.
REQ-013: The state machine SHALL have states EMPTY (0 entries), BUSY (main holds 1 entry) and FULL (main and skid both hold entries).
REQ-014: out_valid SHALL be 1 in BUSY and FULL; in_ready SHALL be 1 in EMPTY and BUSY; both SHALL be driven directly from state registers.
REQ-015: In EMPTY, in_fire SHALL load main with in_data and move to BUSY.
REQ-016: In BUSY, in_fire without out_fire SHALL load skid and move to FULL.
REQ-017: In BUSY, in_fire with out_fire SHALL load main and stay in BUSY.
REQ-018: In BUSY, out_fire without in_fire SHALL move to EMPTY.
REQ-019: In FULL, out_fire SHALL copy skid into main and move to BUSY.
REQ-020: In any state, a cycle with neither transfer SHALL hold the state and both registers unchanged.
REQ-021: Latency SHALL be one cycle from in_fire to out_valid=1 with that payload.
REQ-022: Sustained throughput SHALL be one transfer per cycle when in_valid=1 and out_ready=1.
REQ-023: Payloads SHALL leave in acceptance order with no loss and no duplication.
REQ-024: out_data SHALL be stable while out_valid=1 and out_ready=0.

Reset
REQ-025: While reset=0 at a rising edge, the next state SHALL be EMPTY and main and skid SHALL clear to 0.
REQ-026: in_ready and out_valid SHALL be forced to 0 while reset is low.
REQ-027: After release, out_data SHALL read 0, out_valid SHALL read 0 and in_ready SHALL read 1.
REQ-028: A reset mid-stream SHALL discard all held entries with no output transfer completing on that edge.

Configuration
REQ-029: With SKID_BUFFER_FLUSH_EN defined, a flush input port SHALL exist.
REQ-030: With SKID_BUFFER_FLUSH_EN defined, flush=1 at a rising edge SHALL move the state to EMPTY and discard all held entries, taking priority over in_fire and out_fire.
REQ-031: With SKID_BUFFER_FLUSH_EN defined, in_ready SHALL be forced to 0 while flush=1.
REQ-032: With SKID_BUFFER_FLUSH_EN defined, reset SHALL take priority over flush.
REQ-033: Without SKID_BUFFER_FLUSH_EN, the flush port SHALL be absent and behaviour SHALL be as specified in REQ-011 to REQ-028.

Verification
REQ-034: Reset held low 2 cycles, then released -> out_valid=0, in_ready=1, out_data=0.
REQ-035: Stream 0x1..0x8 with out_ready=1 -> out_data 0x1..0x8 on consecutive cycles, first one cycle after the first accept, in_ready stays 1.
REQ-036: Send 0xA then 0xB with out_ready=0 -> state FULL, in_ready=0, out_data=0xA held; raise out_ready -> 0xA then 0xB, in_ready returns to 1 after the first output.
REQ-037: Random in_valid and out_ready, 1000 cycles -> output sequence equals the accepted input sequence in order, with no drops or duplicates.
REQ-038: In FULL with 0xC and 0xD held, drive reset=0 for 1 cycle -> out_valid=0, in_ready=1 after release, and 0xC and 0xD are never output.
REQ-039: Under SKID_BUFFER_FLUSH_EN, in FULL with in_valid=1, pulse flush -> in_ready=0 during the pulse, next cycle state EMPTY and out_valid=0, and the flushed payloads are never output.
